// File: rtl/greenhouse_pkg.sv
// Shared constants and types for the greenhouse telemetry frame writer.
// Payload layout, status bit positions and serializer states live here.
package greenhouse_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         FRAME_LEN     = 12;

    localparam int P_TEMP     = 0;
    localparam int P_HUM      = 1;
    localparam int P_SOIL     = 2;
    localparam int P_CO2      = 3;
    localparam int P_LIGHT    = 4;
    localparam int P_PRESS    = 5;
    localparam int P_PH       = 6;
    localparam int P_PEST     = 7;
    localparam int P_LEAF_IN  = 8;
    localparam int P_LEAF_HLT = 9;
    localparam int P_GROWTH   = 10;
    localparam int P_STATUS   = 11;

    localparam int ST_FAN   = 0;
    localparam int ST_IRR   = 1;
    localparam int ST_HC    = 2;
    localparam int ST_ALERT = 3;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_SEQ, S_LEN, S_PAYLOAD, S_CKSUM
    } tx_state_t;

    // Two's complement of SEQ + LEN + payload, so SEQ..CKSUM sums to zero.
    function automatic logic [7:0] frame_cksum(input logic [7:0] seq,
                                               input logic [FRAME_LEN-1:0][7:0] pl);
        logic [7:0] sum;
        sum = seq + 8'(FRAME_LEN);
        for (int i = 0; i < FRAME_LEN; i++) sum = sum + pl[i];
        return 8'(~sum + 8'd1);
    endfunction

endpackage

// File: rtl/sensor_frame_tx_ticker.sv
// Free-running sample period counter; emits a one-cycle tick at the terminal
// count while logging is enabled and sits at zero otherwise.
module sample_ticker #(
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic log_en,
    output logic tick
);
    localparam logic [19:0] TERM = 20'(SAMPLE_PERIOD - 1);

    logic [19:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || !log_en)  r_cnt <= '0;
        else if (r_cnt == TERM) r_cnt <= '0;
        else                 r_cnt <= r_cnt + 20'd1;
    end

    assign tick = log_en && (r_cnt == TERM);

endmodule

// File: rtl/sensor_frame_tx.sv
// Snapshots the sensor/monitor state on a trigger and streams it as a framed,
// checksummed 16-byte record over a valid/ready byte interface.
module sensor_frame_tx
    import greenhouse_pkg::*;
#(
    parameter int         SAMPLE_PERIOD = 1000,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] temperature,
    input  logic [7:0] humidity,
    input  logic [7:0] soil_moisture,
    input  logic [7:0] co2_level,
    input  logic [7:0] light_intensity,
    input  logic [7:0] pressure,
    input  logic [7:0] ph_level,
    input  logic [7:0] pest_level,
    input  logic [7:0] leaf_color_in,
    input  logic [7:0] leaf_health_out,
    input  logic [7:0] growth_status,
    input  logic       fan,
    input  logic       irrigation,
    input  logic       humidity_control,
    input  logic       alert,
    input  logic       log_en,
    input  logic       snap_req,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] drop_count
);
    tx_state_t                   r_state, w_state_nxt;
    logic [FRAME_LEN-1:0][7:0]   r_snap, w_payload;
    logic [7:0]                  r_seq, r_drop;
    logic [3:0]                  r_idx;
    logic                        w_tick, w_trig, w_hs;

    sample_ticker #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_ticker (
        .clk    (clk),
        .rst    (rst),
        .log_en (log_en),
        .tick   (w_tick)
    );

    assign w_trig     = w_tick | snap_req;
    assign w_hs       = tx_valid & tx_ready;
    assign drop_count = r_drop;

    always_comb begin
        w_payload             = '0;
        w_payload[P_TEMP]     = temperature;
        w_payload[P_HUM]      = humidity;
        w_payload[P_SOIL]     = soil_moisture;
        w_payload[P_CO2]      = co2_level;
        w_payload[P_LIGHT]    = light_intensity;
        w_payload[P_PRESS]    = pressure;
        w_payload[P_PH]       = ph_level;
        w_payload[P_PEST]     = pest_level;
        w_payload[P_LEAF_IN]  = leaf_color_in;
        w_payload[P_LEAF_HLT] = leaf_health_out;
        w_payload[P_GROWTH]   = growth_status;
        w_payload[P_STATUS][ST_FAN]   = fan;
        w_payload[P_STATUS][ST_IRR]   = irrigation;
        w_payload[P_STATUS][ST_HC]    = humidity_control;
        w_payload[P_STATUS][ST_ALERT] = alert;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_snap  <= '0;
            r_seq   <= '0;
            r_idx   <= '0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nxt;
            // A trigger only lands when idle; otherwise it is counted as lost.
            if (w_trig) begin
                if (r_state == S_IDLE)  r_snap <= w_payload;
                else if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
            end
            if (w_hs && r_state == S_LEN)     r_idx <= '0;
            if (w_hs && r_state == S_PAYLOAD) r_idx <= r_idx + 4'd1;
            if (w_hs && r_state == S_CKSUM)   r_seq <= r_seq + 8'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tx_valid    = (r_state != S_IDLE);
        busy        = (r_state != S_IDLE);
        tx_data     = '0;
        frame_done  = 1'b0;
        case (r_state)
            S_IDLE:    if (w_trig) w_state_nxt = S_SYNC;
            S_SYNC: begin
                tx_data = SYNC_BYTE;
                if (w_hs) w_state_nxt = S_SEQ;
            end
            S_SEQ: begin
                tx_data = r_seq;
                if (w_hs) w_state_nxt = S_LEN;
            end
            S_LEN: begin
                tx_data = 8'(FRAME_LEN);
                if (w_hs) w_state_nxt = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                tx_data = r_snap[r_idx];
                if (w_hs && r_idx == 4'(FRAME_LEN - 1)) w_state_nxt = S_CKSUM;
            end
            S_CKSUM: begin
                tx_data    = frame_cksum(r_seq, r_snap);
                frame_done = tx_ready;
                if (w_hs) w_state_nxt = S_IDLE;
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_sensor_frame_tx.sv
// Bench for sensor_frame_tx: an abstract frame-queue model checked every cycle,
// plus hand-computed literal frames for the directed scenarios.
module tb_sensor_frame_tx;
    localparam int P = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] temperature = 0, humidity = 0, soil_moisture = 0, co2_level = 0;
    logic [7:0] light_intensity = 0, pressure = 0, ph_level = 0, pest_level = 0;
    logic [7:0] leaf_color_in = 0, leaf_health_out = 0, growth_status = 0;
    logic       fan = 0, irrigation = 0, humidity_control = 0, alert = 0;
    logic       log_en = 0, snap_req = 0, tx_ready = 0;
    logic [7:0] tx_data, drop_count;
    logic       tx_valid, busy, frame_done;

    sensor_frame_tx #(.SAMPLE_PERIOD(P)) dut (
        .clk(clk), .rst(rst),
        .temperature(temperature), .humidity(humidity), .soil_moisture(soil_moisture),
        .co2_level(co2_level), .light_intensity(light_intensity), .pressure(pressure),
        .ph_level(ph_level), .pest_level(pest_level), .leaf_color_in(leaf_color_in),
        .leaf_health_out(leaf_health_out), .growth_status(growth_status),
        .fan(fan), .irrigation(irrigation), .humidity_control(humidity_control), .alert(alert),
        .log_en(log_en), .snap_req(snap_req),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .frame_done(frame_done), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_chk = 0;
    logic [7:0] q[$];      // bytes the model still expects to see on the link
    logic [7:0] acc[$];    // bytes actually accepted by the sink
    int m_seq = 0, m_drop = 0, m_le = 0, frames = 0;
    logic prev_v = 0, prev_r = 0, prev_rst = 1;
    logic [7:0] prev_d = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic void push_frame();
        logic [7:0] pl[12];
        int s;
        pl = '{temperature, humidity, soil_moisture, co2_level, light_intensity, pressure,
               ph_level, pest_level, leaf_color_in, leaf_health_out, growth_status,
               {4'b0, alert, humidity_control, irrigation, fan}};
        q.push_back(8'hA5);
        q.push_back(8'(m_seq));
        q.push_back(8'd12);
        s = m_seq + 12;
        foreach (pl[i]) begin q.push_back(pl[i]); s += pl[i]; end
        q.push_back(8'((256 - (s % 256)) % 256));
    endfunction

    // Per-cycle compare, then advance the model across the coming edge.
    always @(negedge clk) begin
        logic bz, tick;
        chk("tx_valid", tx_valid, q.size() > 0);
        chk("busy", busy, q.size() > 0);
        if (q.size() > 0) chk("tx_data", tx_data, q[0]);
        chk("frame_done", frame_done, (q.size() == 1) && tx_ready);
        chk("drop_count", drop_count, 8'(m_drop));
        if (prev_v && !prev_r && !prev_rst) begin
            chk("stall_valid", tx_valid, 1);
            chk("stall_data", tx_data, prev_d);
        end
        prev_v = tx_valid; prev_r = tx_ready; prev_d = tx_data; prev_rst = rst;
        if (tx_valid && tx_ready && !rst) acc.push_back(tx_data);
        if (frame_done && !rst) frames++;
        if (rst) begin
            q.delete(); m_seq = 0; m_drop = 0; m_le = 0;
        end else begin
            bz = (q.size() > 0);
            if (bz && tx_ready) void'(q.pop_front());
            tick = 0;
            if (log_en) begin
                m_le++;
                if (m_le == P) begin tick = 1; m_le = 0; end
            end else m_le = 0;
            if (tick || snap_req) begin
                if (bz) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                else begin push_frame(); m_seq = (m_seq + 1) % 256; end
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            step();
            if (!busy && q.size() == 0) break;
        end
        chk("idle_timeout", (i < budget), 1);
    endtask

    task automatic set_basic();
        temperature = 25; humidity = 50; soil_moisture = 50; co2_level = 40;
        light_intensity = 60; pressure = 101; ph_level = 60; pest_level = 10;
        leaf_color_in = 80; leaf_health_out = 80; growth_status = 0;
        fan = 1; irrigation = 1; humidity_control = 1; alert = 0;
    endtask

    logic [7:0] basic[16] = '{8'hA5, 8'h00, 8'h0C, 8'h19, 8'h32, 8'h32, 8'h28, 8'h3C,
                              8'h65, 8'h3C, 8'h0A, 8'h50, 8'h50, 8'h00, 8'h07, 8'hC1};

    initial begin
        int hold, s, c;
        repeat (3) step();
        rst = 0;

        // Basic frame
        set_basic(); tx_ready = 1; acc.delete();
        snap_req = 1; step(); snap_req = 0;
        wait_idle(100);
        chk("basic_len", acc.size(), 16);
        for (int i = 0; i < 16 && i < acc.size(); i++) chk($sformatf("basic_b%0d", i), acc[i], basic[i]);

        // Backpressure: alternating ready, five-cycle stall at byte 7
        acc.delete(); tx_ready = 0; hold = 0;
        snap_req = 1; step(); snap_req = 0;
        for (c = 0; c < 300 && busy; c++) begin
            if (acc.size() == 7 && hold < 5) begin tx_ready = 0; hold++; end
            else tx_ready = !tx_ready;
            step();
        end
        chk("bp_timeout", (c < 300), 1);
        chk("bp_hold", hold, 5);
        chk("bp_len", acc.size(), 16);
        if (acc.size() == 16) begin
            chk("bp_sync", acc[0], 8'hA5);
            chk("bp_seq", acc[1], 8'h01);
            chk("bp_len_byte", acc[2], 8'h0C);
            for (int i = 3; i < 15; i++) chk($sformatf("bp_pl%0d", i), acc[i], basic[i]);
            chk("bp_cksum", acc[15], 8'hC0);
        end

        // Drops while busy, inputs changed mid-frame
        tx_ready = 1; acc.delete();
        snap_req = 1; step(); snap_req = 0; step();
        snap_req = 1; step(); snap_req = 0;
        temperature = 8'hFF; humidity = 8'h11; pest_level = 8'h99; alert = 1; fan = 0;
        step();
        snap_req = 1; step(); snap_req = 0; step();
        snap_req = 1; step(); snap_req = 0;
        wait_idle(100);
        chk("drop_cnt3", drop_count, 3);
        chk("drop_len", acc.size(), 16);
        if (acc.size() == 16) begin
            chk("drop_seq", acc[1], 8'h02);
            for (int i = 3; i < 15; i++) chk($sformatf("drop_pl%0d", i), acc[i], basic[i]);
            chk("drop_cksum", acc[15], 8'hBF);
        end
        set_basic();

        // Periodic ticks; manual request coinciding with the second tick
        frames = 0; log_en = 1;
        for (int i = 1; i <= 300; i++) begin
            snap_req = (i == 80);
            step();
        end
        snap_req = 0; log_en = 0;
        wait_idle(100);
        chk("periodic_frames", frames, 7);
        chk("periodic_drops", drop_count, 3);

        // Sequence wrap over 257 frames
        rst = 1; step(); rst = 0;
        acc.delete(); tx_ready = 1;
        for (int f = 0; f < 257; f++) begin
            temperature = 8'(f * 7);
            snap_req = 1; step(); snap_req = 0;
            wait_idle(40);
        end
        chk("wrap_len", acc.size(), 257 * 16);
        if (acc.size() == 257 * 16) begin
            chk("wrap_seq_ff", acc[255 * 16 + 1], 8'hFF);
            chk("wrap_seq_00", acc[256 * 16 + 1], 8'h00);
            for (int f = 255; f < 257; f++) begin
                s = 0;
                for (int i = 1; i < 16; i++) s += acc[f * 16 + i];
                chk($sformatf("wrap_sum%0d", f), s % 256, 0);
            end
        end
        set_basic();

        // Reset in the middle of payload byte 5 while stalled
        acc.delete(); tx_ready = 1;
        snap_req = 1; step(); snap_req = 0;
        for (c = 0; c < 50 && acc.size() < 8; c++) step();
        tx_ready = 0;
        step();
        chk("mid_valid_pre", tx_valid, 1);
        rst = 1; step(); rst = 0;
        chk("rst_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", drop_count, 0);
        acc.delete(); tx_ready = 1;
        snap_req = 1; step(); snap_req = 0;
        wait_idle(100);
        chk("rst_len", acc.size(), 16);
        if (acc.size() >= 2) begin
            chk("rst_sync", acc[0], 8'hA5);
            chk("rst_seq", acc[1], 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sensor_frame_tx.md
Name: sensor_frame_tx

Overview:
Telemetry transmitter for the greenhouse monitor. It snapshots the sensor inputs, the refined leaf health, the growth status and the actuator/alert state into one record. It serializes each record as a framed, checksummed byte stream over a valid/ready byte interface, which feeds the downstream UART/log sink. It is the hardware writer of the per-sample log record: one frame per sample tick or manual request.

Parameters:
SAMPLE_PERIOD, 1000, clock cycles between automatic snapshots when log_en=1 (legal range 2..2^20).
SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
temperature, humidity, soil_moisture, co2_level, light_intensity, pressure, ph_level, pest_level, leaf_color_in  in  8 each  raw sensor bytes
leaf_health_out  in  8  refined leaf health from the monitor
growth_status  in  8  growth status from the monitor
fan, irrigation, humidity_control, alert  in  1 each  actuator/alert state
log_en  in  1  enables the periodic sample tick
snap_req  in  1  single-cycle manual snapshot request
tx_data  out  8  frame byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts the byte when tx_valid and tx_ready are both 1
busy  out  1  a frame is in flight
frame_done  out  1  one-cycle pulse when the checksum byte is accepted
drop_count  out  8  triggers lost while busy; saturates at 255

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Outputs: tx_valid=0, tx_data=0, busy=0, frame_done=0, drop_count=0.
  - Internal: seq=0, period counter=0, FSM=IDLE.
  - Reset mid-frame aborts the frame immediately; no partial-frame completion.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 while log_en=1; tick at the terminal count, then wraps to 0.
  - log_en=0 holds the counter at 0.
- Trigger = tick OR snap_req. A simultaneous tick and snap_req is one trigger.
- Trigger in IDLE:
  - Capture all 12 payload bytes in the same cycle.
  - Next cycle: FSM=SYNC, tx_valid=1, tx_data=SYNC_BYTE, busy=1.
  - Latency is 1 cycle from trigger to the first byte valid.
- Trigger while busy (including the cycle the checksum is accepted): the trigger is dropped, drop_count increments (saturating), and the snapshot is unchanged.
- Frame, 16 bytes:
  - SYNC
  - SEQ
  - LEN=8'd12
  - 12 payload bytes
  - CKSUM
- Payload order: temperature, humidity, soil_moisture, co2_level, light_intensity, pressure, ph_level, pest_level, leaf_color_in, leaf_health_out, growth_status, status.
- status byte = {4'b0, alert, humidity_control, irrigation, fan}.
- CKSUM:
  - Two's complement of the 8-bit modulo-256 sum of SEQ, LEN and the 12 payload bytes.
  - The sum of SEQ through CKSUM is therefore 0 mod 256; SYNC is excluded.
  - Accumulate the sum as bytes are accepted, or precompute it from the snapshot. Either way, only the CKSUM value is checked.
- FSM states: IDLE -> SYNC -> SEQ -> LEN -> PAYLOAD (4-bit index 0..11) -> CKSUM -> IDLE.
  - Each transition occurs only on a handshake (tx_valid & tx_ready).
- Handshake rules:
  - While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
  - tx_valid never deasserts without acceptance except on rst.
  - tx_ready may be held high continuously; the frame then takes exactly 16 cycles.
- Completion: on CKSUM acceptance, pulse frame_done for 1 cycle, busy=0 and tx_valid=0 next cycle, then seq <= seq+1 (wrapping 255->0).
- Inputs changing mid-frame do not affect the frame, which is built from the snapshot only.

Decomposition:
- Shared package greenhouse_pkg:
  - SYNC_BYTE default and FRAME_LEN=12.
  - Payload index constants.
  - Status bit positions.
  - FSM state enumeration.
- One natural sub-module: sample_ticker (period counter plus log_en gating, producing the tick). The serializer FSM and checksum stay in the top module.

Test Plan:
- Basic frame:
  - Stimulus: after reset, set temp=25, hum=50, soil=50, co2=40, light=60, press=101, ph=60, pest=10, leaf_in=80, leaf_health=80, growth=0, fan/irr/hc=1, alert=0. Pulse snap_req, tx_ready=1.
  - Response: 16 consecutive bytes A5,00,0C,19,32,32,28,3C,65,3C,0A,50,50,00,07,C1; frame_done pulses on the C1 byte; next frame carries SEQ=01.
- Backpressure:
  - Stimulus: same frame; toggle tx_ready 0/1 every cycle and hold it 0 for 5 cycles at byte 7.
  - Response: tx_data stable while stalled; byte sequence identical to the basic frame.
- Drop and snapshot stability:
  - Stimulus: 3 snap_req pulses while busy; change the sensor inputs mid-frame.
  - Response: drop_count=3; the frame payload still matches the trigger-time snapshot.
- Periodic ticks:
  - Stimulus: log_en=1, SAMPLE_PERIOD=40, tx_ready=1, run 300 cycles.
  - Response: a frame starts every 40 cycles; SEQ increments 0,1,2,...; simultaneous tick and snap_req yields one frame, drop_count unchanged.
- Sequence wrap:
  - Stimulus: 257 frames.
  - Response: SEQ goes FF then 00; checksum still makes the SEQ..CKSUM sum 0 mod 256.
- Reset mid-frame:
  - Stimulus: assert rst at payload byte 5 with tx_ready=0.
  - Response: next cycle tx_valid=0, busy=0, drop_count=0; the next snap_req frame starts with A5,00.
